// File: rtl/signmag_divrem_seq_pkg.sv
// Shared definitions for the sign-magnitude divide/remainder sequencer:
// default operand width, FSM state encodings and the sign-bit position helper.
package signmag_divrem_seq_pkg;

    localparam int DEFAULT_WIDTH = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Sign bit index of a sign-magnitude word; the magnitude sits below it.
    function automatic int sign_bit(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/signmag_divrem_seq_divrem_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor and keep the
// difference only when it does not go negative.
module divrem_step #(
    parameter int M = 2
) (
    input  logic [M:0]   i_r,
    input  logic         i_q_msb,
    input  logic [M-1:0] i_d,
    output logic [M:0]   o_r_next,
    output logic         o_q_bit
);

    logic [M:0]   w_shifted;
    logic [M+1:0] w_trial;

    // The trial is one bit wider than the remainder so its top bit is a
    // clean borrow flag regardless of the remainder's upper bit.
    assign w_shifted = {i_r[M-1:0], i_q_msb};
    assign w_trial   = {i_r, i_q_msb} - {2'b00, i_d};
    assign o_q_bit   = ~w_trial[M+1];
    assign o_r_next  = o_q_bit ? w_trial[M:0] : w_shifted;

endmodule

// File: rtl/signmag_divrem_seq.sv
// Multi-cycle sign-magnitude divide/remainder sequencer. A start in IDLE
// latches the operands; CALC retires one quotient bit per clock; results
// are registered on entry to DONE and o_done pulses the following cycle.
module signmag_divrem_seq
    import signmag_divrem_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_DZ,
    output logic             o_Z,
    output logic             o_SF
);

    localparam int M  = WIDTH - 1;
    localparam int SB = sign_bit(WIDTH);
    localparam int CW = $clog2(M + 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [M:0]       r_r;
    logic [M-1:0]     r_q;
    logic [M-1:0]     r_d;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;
    logic             r_z;
    logic             r_done;

    logic [M:0]       w_r_next;
    logic             w_q_bit;
    logic [M-1:0]     w_q_next;
    logic             w_q_sign;
    logic [M-1:0]     w_b_mag;

    divrem_step #(
        .M (M)
    ) u_step (
        .i_r      (r_r),
        .i_q_msb  (r_q[M-1]),
        .i_d      (r_d),
        .o_r_next (w_r_next),
        .o_q_bit  (w_q_bit)
    );

    assign w_q_next = {r_q[M-2:0], w_q_bit};
    // A zero quotient is always reported as +0.
    assign w_q_sign = (w_q_next != '0) & (r_sign_a ^ r_sign_b);
    assign w_b_mag  = i_B[M-1:0];

    // FSM, restoring datapath and result registers.
    always_ff @(posedge i_clk) begin
        // NOTE: every register here, datapath included, is cleared by reset so
        // an aborted operation leaves no stale partial state or results behind.
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_r      <= '0;
            r_q      <= '0;
            r_d      <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dz     <= 1'b0;
            r_z      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge value of its neighbours, independent of statement order.
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_sign_a <= i_A[SB];
                        r_sign_b <= i_B[SB];
                        r_q      <= i_A[M-1:0];
                        r_d      <= w_b_mag;
                        r_r      <= '0;
                        r_cnt    <= '0;
                        if (w_b_mag == '0) begin
                            // Divide by zero: dividend passes through as remainder.
                            r_quo   <= '0;
                            r_rem   <= i_A;
                            r_z     <= (i_A[M-1:0] == '0);
                            r_dz    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(M - 1)) begin
                        // Last step: capture results straight from the step output.
                        r_quo   <= {w_q_sign, w_q_next};
                        r_rem   <= {r_sign_a, w_r_next[M-1:0]};
                        r_z     <= (w_r_next[M-1:0] == '0);
                        r_dz    <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                // NOTE: the unused encoding recovers to IDLE rather than locking up.
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = r_done;
    assign o_quo  = r_quo;
    assign o_rem  = r_rem;
    assign o_DZ   = r_dz;
    assign o_Z    = r_z;
    assign o_SF   = r_rem[SB];

endmodule
